// File: rtl/bitrev_output_buffer.sv
// bitrev_output_buffer
//   Ping-pong reorder buffer for the FFT output end. Samples of a frame arrive
//   in bit-reversed index order (the k-th sample is X[bitrev(k)]) and leave in
//   natural order X[0..N-1]. Two N-entry banks let one frame fill while the
//   previous one drains, so the buffer sustains one sample per clock.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   s_valid    input sample valid
//   s_ready    buffer can accept an input sample (registered state only)
//   s_re/s_im  input sample, signed WIDTH-bit components
//   s_last     marks last sample of an input frame; only checked, never resyncs
//   m_valid    output sample valid
//   m_ready    downstream accepts output sample
//   m_re/m_im  output sample in natural order, combinational from bank registers
//   m_last     high with output sample index N-1
//   frame_err  sticky flag: s_last disagreed with the write count
module bitrev_output_buffer #(
    parameter int WIDTH = 16,
    parameter int LOG2N = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_re,
    input  logic [WIDTH-1:0] s_im,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_re,
    output logic [WIDTH-1:0] m_im,
    output logic             m_last,
    output logic             frame_err
);

    localparam int N = 1 << LOG2N;

    logic [2*WIDTH-1:0] mem [2][N];

    logic [LOG2N-1:0] wcnt;
    logic [LOG2N-1:0] rcnt;
    logic             wbank;
    logic             rbank;
    logic [1:0]       full;
    logic [1:0]       full_nxt;

    logic             s_fire;
    logic             m_fire;
    logic             wlast;
    logic             rlast;
    logic [2*WIDTH-1:0] rdata;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < LOG2N; i++) begin
            r[i] = v[LOG2N-1-i];
        end
        return r;
    endfunction

    assign s_ready = ~full[wbank];
    assign m_valid = full[rbank];
    assign s_fire  = s_valid & s_ready;
    assign m_fire  = m_valid & m_ready;
    assign wlast   = (wcnt == '1);
    assign rlast   = (rcnt == '1);

    assign rdata   = mem[rbank][rcnt];
    assign m_re    = rdata[2*WIDTH-1:WIDTH];
    assign m_im    = rdata[WIDTH-1:0];
    assign m_last  = m_valid & rlast;

    // A write only targets an empty bank and a read only frees a full one, so
    // when both complete on the same edge they always touch different banks.
    always_comb begin
        full_nxt = full;
        if (s_fire && wlast) begin
            full_nxt[wbank] = 1'b1;
        end
        if (m_fire && rlast) begin
            full_nxt[rbank] = 1'b0;
        end
    end

    // Bank storage is deliberately not reset; the full bits gate visibility.
    always_ff @(posedge clk) begin
        if (s_fire) begin
            mem[wbank][bitrev(wcnt)] <= {s_re, s_im};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt      <= '0;
            rcnt      <= '0;
            wbank     <= 1'b0;
            rbank     <= 1'b0;
            full      <= '0;
            frame_err <= 1'b0;
        end else begin
            full <= full_nxt;
            if (s_fire) begin
                // Counter wraps to zero naturally after N-1.
                wcnt <= wcnt + 1'b1;
                if (wlast) begin
                    wbank <= ~wbank;
                end
                if (s_last != wlast) begin
                    frame_err <= 1'b1;
                end
            end
            if (m_fire) begin
                rcnt <= rcnt + 1'b1;
                if (rlast) begin
                    rbank <= ~rbank;
                end
            end
        end
    end

endmodule

// File: tb/tb_bitrev_output_buffer.sv
// Directed and randomized bench for bitrev_output_buffer (WIDTH=16, N=8).
module tb_bitrev_output_buffer;

    localparam int WIDTH = 16;
    localparam int LOG2N = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [WIDTH-1:0] s_re = '0;
    logic [WIDTH-1:0] s_im = '0;
    logic             s_last = 1'b0;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [WIDTH-1:0] m_re;
    logic [WIDTH-1:0] m_im;
    logic             m_last;
    logic             frame_err;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Hand-written 3-bit reversal table.
    int br [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    always #5 clk = ~clk;

    bitrev_output_buffer #(
        .WIDTH(WIDTH),
        .LOG2N(LOG2N)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_re     (s_re),
        .s_im     (s_im),
        .s_last   (s_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_re     (m_re),
        .m_im     (m_im),
        .m_last   (m_last),
        .frame_err(frame_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset mid-frame with one full bank and a partial frame pending.
    task automatic test_reset();
        int seen = 0;
        rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_last = 1'b0;
        tick(); tick();
        total_cnt++;
        if ({s_ready, m_valid, m_last, frame_err} !== 4'b1000)
            $display("FAIL reset_idle: s_ready,m_valid,m_last,frame_err=%b expected 1000",
                     {s_ready, m_valid, m_last, frame_err});
        else pass_cnt++;
        @(negedge clk); rst_n = 1'b1;
        tick();
        for (int k = 0; k < 11; k++) begin
            s_valid = 1'b1;
            s_re = 16'(16'h0AA0 + k);
            s_im = 16'(16'h0BB0 + k);
            s_last = (k == 1);
            tick();
        end
        s_valid = 1'b0; s_last = 1'b0;
        total_cnt++;
        if ({m_valid, frame_err} !== 2'b11)
            $display("FAIL reset_precond: m_valid,frame_err=%b expected 11", {m_valid, frame_err});
        else pass_cnt++;
        #3 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({s_ready, m_valid, frame_err} !== 3'b100)
            $display("FAIL reset_async: s_ready,m_valid,frame_err=%b expected 100",
                     {s_ready, m_valid, frame_err});
        else pass_cnt++;
        @(negedge clk); rst_n = 1'b1; m_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (m_valid) seen++;
            tick();
        end
        m_ready = 1'b0;
        total_cnt++;
        if (seen !== 0)
            $display("FAIL reset_discard: %0d stale outputs seen, expected 0", seen);
        else pass_cnt++;
    endtask

    // One frame of re=k*10, im=-k*10; checks latency, order and m_last.
    task automatic test_single_frame();
        logic [WIDTH-1:0] exp_re;
        m_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            s_valid = 1'b1;
            s_re = 16'(k * 10);
            s_im = 16'(-(k * 10));
            s_last = (k == 7);
            if (k == 0) begin
                total_cnt++;
                if (s_ready !== 1'b1) $display("FAIL t2_ready: s_ready=%b expected 1", s_ready);
                else pass_cnt++;
            end
            if (k == 7) begin
                total_cnt++;
                if (m_valid !== 1'b0) $display("FAIL t2_early_valid: m_valid=%b expected 0", m_valid);
                else pass_cnt++;
            end
            tick();
        end
        s_valid = 1'b0; s_last = 1'b0;
        for (int j = 0; j < 8; j++) begin
            exp_re = 16'(br[j] * 10);
            total_cnt++;
            if ({m_valid, m_re, m_im, m_last} !== {1'b1, exp_re, 16'(-int'(exp_re)), (j == 7)})
                $display("FAIL t2_out[%0d]: got v=%b re=%h im=%h last=%b, expected v=1 re=%h im=%h last=%b",
                         j, m_valid, m_re, m_im, m_last, exp_re, 16'(-int'(exp_re)), (j == 7));
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (m_valid !== 1'b0) $display("FAIL t2_drained: m_valid=%b expected 0", m_valid);
        else pass_cnt++;
    endtask

    // Four back-to-back frames with m_ready held high.
    task automatic test_back_to_back();
        int in_idx = 0;
        int out_idx = 0;
        int drops = 0;
        int first_cyc = -1;
        int last_cyc = -1;
        int cyc = 0;
        logic [WIDTH-1:0] exp_re;
        m_ready = 1'b1;
        while (out_idx < 32 && cyc < 80) begin
            if (in_idx < 32) begin
                s_valid = 1'b1;
                s_re = 16'((in_idx / 8) * 256 + in_idx % 8);
                s_im = s_re ^ 16'h7000;
                s_last = (in_idx % 8 == 7);
                if (!s_ready) drops++;
            end else begin
                s_valid = 1'b0;
                s_last = 1'b0;
            end
            if (m_valid) begin
                exp_re = 16'((out_idx / 8) * 256 + br[out_idx % 8]);
                total_cnt++;
                if ({m_re, m_im, m_last} !== {exp_re, exp_re ^ 16'h7000, (out_idx % 8 == 7)})
                    $display("FAIL t3_out[%0d]: got re=%h im=%h last=%b, expected re=%h im=%h last=%b",
                             out_idx, m_re, m_im, m_last, exp_re, exp_re ^ 16'h7000, (out_idx % 8 == 7));
                else pass_cnt++;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                out_idx++;
            end
            if (s_valid && s_ready) in_idx++;
            tick();
            cyc++;
        end
        s_valid = 1'b0; s_last = 1'b0;
        total_cnt++;
        if (out_idx !== 32) $display("FAIL t3_count: got %0d outputs, expected 32", out_idx);
        else pass_cnt++;
        total_cnt++;
        if (drops !== 0) $display("FAIL t3_ready_drop: s_ready low %0d cycles, expected 0", drops);
        else pass_cnt++;
        total_cnt++;
        if (first_cyc !== 8) $display("FAIL t3_latency: first output cycle %0d, expected 8", first_cyc);
        else pass_cnt++;
        total_cnt++;
        if (last_cyc - first_cyc !== 31)
            $display("FAIL t3_gapless: output span %0d cycles, expected 31", last_cyc - first_cyc);
        else pass_cnt++;
    endtask

    // Downstream stalled for 20 cycles while the source keeps offering data.
    task automatic test_backpressure();
        int acc = 0;
        int out = 0;
        int cyc = 0;
        logic [WIDTH-1:0] exp_re;
        m_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            s_valid = 1'b1;
            s_re = 16'(16'h1000 + acc);
            s_im = 16'(16'h2000 + acc);
            s_last = (acc % 8 == 7);
            if (s_ready) acc++;
            tick();
        end
        s_valid = 1'b0; s_last = 1'b0;
        total_cnt++;
        if (acc !== 16) $display("FAIL t4_accepted: got %0d, expected 16", acc);
        else pass_cnt++;
        total_cnt++;
        if ({s_ready, m_valid} !== 2'b01)
            $display("FAIL t4_full: s_ready,m_valid=%b expected 01", {s_ready, m_valid});
        else pass_cnt++;
        m_ready = 1'b1;
        while (out < 16 && cyc < 40) begin
            if (m_valid) begin
                exp_re = 16'(16'h1000 + (out / 8) * 8 + br[out % 8]);
                total_cnt++;
                if ({m_re, m_im, m_last} !== {exp_re, exp_re + 16'h1000, (out % 8 == 7)})
                    $display("FAIL t4_out[%0d]: got re=%h im=%h last=%b, expected re=%h im=%h last=%b",
                             out, m_re, m_im, m_last, exp_re, exp_re + 16'h1000, (out % 8 == 7));
                else pass_cnt++;
                out++;
            end
            tick();
            cyc++;
        end
        total_cnt++;
        if (out !== 16) $display("FAIL t4_count: got %0d outputs, expected 16", out);
        else pass_cnt++;
        total_cnt++;
        if ({s_ready, m_valid} !== 2'b10)
            $display("FAIL t4_empty: s_ready,m_valid=%b expected 10", {s_ready, m_valid});
        else pass_cnt++;
    endtask

    // 100 frames, random valid/ready, data biased toward signed extremes.
    task automatic test_random();
        logic [2*WIDTH:0] q [$];
        logic [2*WIDTH-1:0] fb [8];
        logic [2*WIDTH:0] expv;
        logic [WIDTH-1:0] cur_re;
        logic [WIDTH-1:0] cur_im;
        int wk = 0;
        int fed = 0;
        int outs = 0;
        int cyc = 0;
        int sel;
        cur_re = 16'h8000;
        cur_im = 16'h7FFF;
        while ((fed < 800 || outs < 800) && cyc < 20000) begin
            s_valid = (fed < 800) ? 1'($urandom_range(0, 1)) : 1'b0;
            s_re = cur_re;
            s_im = cur_im;
            s_last = (wk == 7);
            m_ready = 1'($urandom_range(0, 1));
            if (m_valid && m_ready) begin
                total_cnt++;
                if (q.size() == 0) begin
                    $display("FAIL t5_spurious: output re=%h im=%h with empty scoreboard, expected none",
                             m_re, m_im);
                end else begin
                    expv = q.pop_front();
                    if ({m_re, m_im, m_last} !== expv)
                        $display("FAIL t5_out[%0d]: got re=%h im=%h last=%b, expected re=%h im=%h last=%b",
                                 outs, m_re, m_im, m_last, expv[32:17], expv[16:1], expv[0]);
                    else pass_cnt++;
                end
                outs++;
            end
            if (s_valid && s_ready) begin
                fb[br[wk]] = {cur_re, cur_im};
                wk++;
                fed++;
                if (wk == 8) begin
                    for (int j = 0; j < 8; j++) q.push_back({fb[j], (j == 7)});
                    wk = 0;
                end
                sel = int'($urandom_range(0, 3));
                cur_re = (sel == 0) ? 16'h8000 : (sel == 1) ? 16'h7FFF : 16'($urandom);
                sel = int'($urandom_range(0, 3));
                cur_im = (sel == 0) ? 16'h7FFF : (sel == 1) ? 16'h8000 : 16'($urandom);
            end
            tick();
            cyc++;
        end
        s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
        total_cnt++;
        if (outs !== 800 || q.size() !== 0)
            $display("FAIL t5_count: got %0d outputs with %0d pending, expected 800 and 0", outs, q.size());
        else pass_cnt++;
        total_cnt++;
        if (frame_err !== 1'b0) $display("FAIL t5_frame_err: frame_err=%b expected 0", frame_err);
        else pass_cnt++;
    endtask

    // s_last on the 5th sample: sticky error, data still framed by count.
    task automatic test_framing();
        logic [WIDTH-1:0] exp_re;
        int out = 0;
        int cyc = 0;
        total_cnt++;
        if (frame_err !== 1'b0) $display("FAIL t6_clean: frame_err=%b expected 0", frame_err);
        else pass_cnt++;
        m_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            s_valid = 1'b1;
            s_re = 16'(16'h0300 + k);
            s_im = 16'(16'h0400 + k);
            s_last = (k == 4);
            tick();
            if (k == 3) begin
                total_cnt++;
                if (frame_err !== 1'b0) $display("FAIL t6_before: frame_err=%b expected 0", frame_err);
                else pass_cnt++;
            end
            if (k == 4) begin
                total_cnt++;
                if (frame_err !== 1'b1) $display("FAIL t6_set: frame_err=%b expected 1", frame_err);
                else pass_cnt++;
            end
        end
        s_valid = 1'b0; s_last = 1'b0;
        m_ready = 1'b1;
        while (out < 8 && cyc < 30) begin
            if (m_valid) begin
                exp_re = 16'(16'h0300 + br[out]);
                total_cnt++;
                if ({m_re, m_im, m_last} !== {exp_re, exp_re + 16'h0100, (out == 7)})
                    $display("FAIL t6_out[%0d]: got re=%h im=%h last=%b, expected re=%h im=%h last=%b",
                             out, m_re, m_im, m_last, exp_re, exp_re + 16'h0100, (out == 7));
                else pass_cnt++;
                out++;
            end
            tick();
            cyc++;
        end
        total_cnt++;
        if (out !== 8) $display("FAIL t6_count: got %0d outputs, expected 8", out);
        else pass_cnt++;
        // A correctly framed frame afterwards must not clear the flag.
        for (int k = 0; k < 8; k++) begin
            s_valid = 1'b1;
            s_re = 16'(k);
            s_im = 16'(k);
            s_last = (k == 7);
            tick();
        end
        s_valid = 1'b0; s_last = 1'b0;
        for (int c = 0; c < 12; c++) tick();
        total_cnt++;
        if ({frame_err, m_valid} !== 2'b10)
            $display("FAIL t6_sticky: frame_err,m_valid=%b expected 10", {frame_err, m_valid});
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_framing();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
